// File: rtl/util_axis_1553_decoder.sv
`default_nettype none
// ============================================================================
// Module   : util_axis_1553_decoder
// Purpose  : MIL-STD-1553 Manchester II receiver. Samples the bus diff pair
//            through a 2-FF synchroniser and detects a cmd/status or data
//            sync. It then decodes 16 data bits plus odd parity and presents
//            each word on an AXI-Stream master port.
// Ports    : aclk           clock, rising edge
//            arstn          synchronous active-low reset
//            diff[1:0]      bus pair (10 = high, 01 = low, 00/11 = idle)
//            m_axis_tdata   decoded word, MSB = first bit on the bus
//            m_axis_tvalid  word valid
//            m_axis_tuser   [7] cmd sync, [6] data sync, [2] overflow,
//                           [1] manchester err, [0] parity err
//            m_axis_tready  downstream ready
// Config   : UTIL_AXIS_1553_DECODER_ERR_FWD_EN -- when defined, aborted and
//            parity-failed words are forwarded with error flags set.
//            When undefined, those words are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module util_axis_1553_decoder #(
  parameter int clock_speed = 20000000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tuser,
  input  logic        m_axis_tready
);
  localparam int HB = clock_speed / 2000000;
  localparam int CW = $clog2(4*HB + 1);
  localparam logic [CW-1:0] c_one    = CW'(1);
  localparam logic [CW-1:0] c_hb     = CW'(HB);
  localparam logic [CW-1:0] c_mid    = CW'(HB/2);
  localparam logic [CW-1:0] c_sync   = CW'(3*HB);
  localparam logic [CW-1:0] c_win_lo = CW'(3*HB - HB/2);
  localparam logic [CW-1:0] c_win_hi = CW'(3*HB + HB/2);
  localparam logic [CW-1:0] c_sat    = CW'(4*HB);

  typedef enum logic [1:0] {S_IDLE, S_SYNC1, S_SYNC2, S_DATA} state_t;
  state_t r_state, w_state_n;

  logic [1:0]    r_meta, r_d, r_prev;
  logic [CW-1:0] r_cnt, r_pos, w_cur_pos;
  logic          r_lvl, r_cmd, r_half, r_h1, r_ovf;
  logic [4:0]    r_nbit;
  logic [15:0]   r_data;
  logic [15:0]   r_tdata;
  logic [7:0]    r_tuser;
  logic          r_tvalid;
  logic          w_hi, w_valid, w_edge, w_run_ok, w_resync, w_cur_half;
  logic          w_samp, w_merr, w_bit_ok, w_done, w_to_data, w_perr, w_emit;
  logic [1:0]    w_err_bits;
  logic [3:0]    w_idx;

  assign w_hi     = (r_d == 2'b10);
  assign w_valid  = (r_d == 2'b10) || (r_d == 2'b01);
  assign w_edge   = (r_d != r_prev);
  assign w_run_ok = (r_cnt >= c_win_lo) && (r_cnt <= c_win_hi);
  assign w_idx    = 4'd15 - r_nbit[3:0];
  // Odd parity over data + parity bit; r_h1 holds the parity bit value here.
  assign w_perr   = w_done && !(^{r_data, r_h1});

`ifdef UTIL_AXIS_1553_DECODER_ERR_FWD_EN
  assign w_emit     = w_done || w_merr;
  assign w_err_bits = {w_merr, w_perr};
`else
  assign w_emit     = w_done && !w_perr;
  assign w_err_bits = 2'b00;
`endif

  always_ff @(posedge aclk) begin
    if (!arstn) r_state <= S_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_resync   = 1'b0;
    w_cur_half = r_half;
    w_cur_pos  = r_pos;
    w_samp     = 1'b0;
    w_merr     = 1'b0;
    w_bit_ok   = 1'b0;
    w_done     = 1'b0;
    w_to_data  = 1'b0;
    case (r_state)
      S_IDLE: if (w_valid) w_state_n = S_SYNC1;
      S_SYNC1: begin
        if (w_valid && (w_hi == r_lvl)) begin
          if (r_cnt >= c_sat - c_one) w_state_n = S_IDLE;
        end else if (w_valid && w_run_ok) begin
          w_state_n = S_SYNC2;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_SYNC2: begin
        // The sync second half may merge with bit 0's first half, so leave
        // at the first edge once the window is open, or at the nominal end.
        if (!w_valid) begin
          w_state_n = S_IDLE;
        end else if (w_hi == r_lvl) begin
          if (r_cnt < c_win_lo) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_DATA;
            w_to_data = 1'b1;
          end
        end else if (r_cnt >= c_sync) begin
          w_state_n = S_DATA;
          w_to_data = 1'b1;
        end
      end
      S_DATA: begin
        // An edge near mid-bit is the Manchester transition: re-centre on it.
        w_resync = w_edge && ((!r_half && (r_pos > c_mid)) || (r_half && (r_pos < c_mid)));
        if (w_resync) begin
          w_cur_half = 1'b1;
          w_cur_pos  = '0;
        end
        if (w_cur_pos == c_mid) begin
          w_samp = 1'b1;
          if (!w_valid || (w_cur_half && (w_hi == r_h1))) begin
            w_merr    = 1'b1;
            w_state_n = S_IDLE;
          end else if (w_cur_half) begin
            w_bit_ok = 1'b1;
            if (r_nbit == 5'd16) begin
              w_done    = 1'b1;
              w_state_n = S_IDLE;
            end
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_meta <= 2'b00;
      r_d    <= 2'b00;
      r_prev <= 2'b00;
      r_cnt  <= '0;
      r_pos  <= '0;
      r_lvl  <= 1'b0;
      r_cmd  <= 1'b0;
      r_half <= 1'b0;
      r_h1   <= 1'b0;
      r_nbit <= 5'd0;
      r_data <= 16'h0000;
    end else begin
      r_meta <= diff;
      r_d    <= r_meta;
      r_prev <= r_d;
      case (r_state)
        S_IDLE: begin
          r_cnt <= c_one;
          r_lvl <= w_hi;
        end
        S_SYNC1: begin
          if (w_state_n == S_SYNC2) begin
            r_cnt <= c_one;
            r_cmd <= r_lvl;
          end else if (r_cnt != c_sat) begin
            r_cnt <= r_cnt + c_one;
          end
        end
        S_SYNC2: if (r_cnt != c_sat) r_cnt <= r_cnt + c_one;
        S_DATA: begin
          if (w_samp && !w_cur_half) r_h1 <= w_hi;
          if (w_bit_ok) begin
            if (r_nbit < 5'd16) r_data[w_idx] <= r_h1;
            r_nbit <= r_nbit + 5'd1;
          end
          if (w_cur_pos == c_hb - c_one) begin
            r_pos  <= '0;
            r_half <= ~w_cur_half;
          end else begin
            r_pos  <= w_cur_pos + c_one;
            r_half <= w_cur_half;
          end
        end
        default: ;
      endcase
      // The current sample is position 0 of bit 0's first half.
      if (w_to_data) begin
        r_pos  <= c_one;
        r_half <= 1'b0;
        r_nbit <= 5'd0;
        r_data <= 16'h0000;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= 16'h0000;
      r_tuser  <= 8'h00;
      r_ovf    <= 1'b0;
    end else begin
      if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
      if (w_emit) begin
        if (!r_tvalid || m_axis_tready) begin
          r_tvalid <= 1'b1;
          r_tdata  <= r_data;
          r_tuser  <= {r_cmd, ~r_cmd, 3'b000, r_ovf, w_err_bits};
          r_ovf    <= 1'b0;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;

endmodule
`default_nettype wire

// File: tb/tb_util_axis_1553_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_util_axis_1553_decoder
// Purpose  : Self-checking bench for util_axis_1553_decoder. A bit-level
//            Manchester generator drives the bus. A word-level model predicts
//            each output beat, including the forwarding macro and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_util_axis_1553_decoder;
  localparam int HB = 10;
  localparam logic [1:0] HI = 2'b10;
  localparam logic [1:0] LO = 2'b01;
  localparam logic [1:0] ID = 2'b00;

  logic        aclk, arstn, m_axis_tready, m_axis_tvalid;
  logic [1:0]  diff;
  logic [15:0] m_axis_tdata;
  logic [7:0]  m_axis_tuser;

  int total = 0;
  int bad   = 0;
  logic [15:0] gd[$], ed[$];
  logic [7:0]  gu[$], eu[$];
  bit m_hold = 0, m_held = 0, m_ovf = 0;

  util_axis_1553_decoder #(.clock_speed(20000000)) dut (
    .aclk(aclk), .arstn(arstn), .diff(diff),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready)
  );

  always #25 aclk = ~aclk;

  // Beat collector plus hold-stability check while back-pressured.
  logic pv = 0, pr = 0;
  logic [15:0] pd = 0;
  logic [7:0]  pu = 0;
  always begin
    @(negedge aclk); #1;
    if (pv && !pr && m_axis_tvalid === 1'b1) begin
      total++;
      if (m_axis_tdata !== pd || m_axis_tuser !== pu) begin
        bad++;
        $display("FAIL hold_stable: tdata=%h tuser=%h, held %h/%h", m_axis_tdata, m_axis_tuser, pd, pu);
      end
    end
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      gd.push_back(m_axis_tdata);
      gu.push_back(m_axis_tuser);
    end
    pv = (m_axis_tvalid === 1'b1);
    pr = m_axis_tready;
    pd = m_axis_tdata;
    pu = m_axis_tuser;
  end

  task automatic drive(input logic [1:0] l, input int n);
    diff = l;
    repeat (n) @(negedge aclk);
  endtask

  // bad: index of a bit (0..16) sent with both halves high, -1 for none.
  task automatic send_word(input bit cmd, input logic [15:0] d, input bit pflip,
                           input int bad_bit, input int s1len);
    logic [16:0] bits;
    bits = {d, (~^d) ^ pflip};
    drive(cmd ? HI : LO, s1len);
    drive(cmd ? LO : HI, 3*HB);
    for (int i = 0; i < 17; i++) begin
      if (i == bad_bit)      begin drive(HI, HB); drive(HI, HB); end
      else if (bits[16-i])   begin drive(HI, HB); drive(LO, HB); end
      else                   begin drive(LO, HB); drive(HI, HB); end
    end
  endtask

  // Word-level prediction of what (if anything) reaches the AXI port.
  task automatic model_word(input bit cmd, input logic [15:0] d, input bit pflip, input int bad_bit);
    bit merr, perr, emit;
    logic [15:0] td;
    merr = (bad_bit >= 0) && (bad_bit <= 16);
    perr = !merr && pflip;
    td   = merr ? 16'((32'hFFFF << (16 - bad_bit)) & {16'h0, d}) : d;
`ifdef UTIL_AXIS_1553_DECODER_ERR_FWD_EN
    emit = 1'b1;
`else
    emit = !merr && !perr;
`endif
    if (!emit) return;
    if (m_hold && m_held) begin
      m_ovf = 1'b1;
      return;
    end
    ed.push_back(td);
    eu.push_back({cmd, !cmd, 3'b000, m_ovf, merr, perr});
    m_ovf = 1'b0;
    if (m_hold) m_held = 1'b1;
  endtask

  task automatic clear_q();
    gd.delete(); gu.delete(); ed.delete(); eu.delete();
  endtask

  task automatic test_reset();
    arstn = 0; m_axis_tready = 1; diff = ID;
    repeat (4) @(negedge aclk);
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== 16'h0000) begin bad++; $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata); end
    total++;
    if (m_axis_tuser !== 8'h00) begin bad++; $display("FAIL reset_tuser: got %h want 00", m_axis_tuser); end
    arstn = 1;
    drive(ID, 5);
  endtask

  task automatic test_cmd_word();
    int n;
    clear_q();
    model_word(1'b1, 16'h8F00, 1'b0, -1);
    n = 0;
    fork
      send_word(1'b1, 16'h8F00, 1'b0, -1, 3*HB);
      begin
        while (m_axis_tvalid !== 1'b1 && n < 600) begin @(negedge aclk); n++; end
      end
    join
    drive(ID, 2*HB);
    total++;
    if (n < 390 || n > 410) begin bad++; $display("FAIL cmd_latency: got %0d cycles want 390..410", n); end
    total++;
    if (gd.size() != ed.size()) begin bad++; $display("FAIL cmd_count: got %0d want %0d", gd.size(), ed.size()); end
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (i >= gd.size() || gd[i] !== ed[i] || gu[i] !== eu[i]) begin
        bad++; $display("FAIL cmd_beat%0d: got %h/%h want %h/%h", i, gd[i], gu[i], ed[i], eu[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    model_word(1'b0, 16'hFFFF, 1'b0, -1);
    model_word(1'b0, 16'h0000, 1'b0, -1);
    send_word(1'b0, 16'hFFFF, 1'b0, -1, 3*HB);
    send_word(1'b0, 16'h0000, 1'b0, -1, 3*HB);
    drive(ID, 4*HB);
    total++;
    if (gd.size() != ed.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", gd.size(), ed.size()); end
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (i >= gd.size() || gd[i] !== ed[i] || gu[i] !== eu[i]) begin
        bad++; $display("FAIL b2b_beat%0d: got %h/%h want %h/%h", i, gd[i], gu[i], ed[i], eu[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit c;
    clear_q();
    c = 1'($urandom_range(0, 1));
    m_axis_tready = 0; m_hold = 1; m_held = 0;
    for (int k = 1; k <= 3; k++) begin
      model_word(c, 16'(k), 1'b0, -1);
      send_word(c, 16'(k), 1'b0, -1, 3*HB);
    end
    drive(ID, 4*HB);
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== ed[0]) begin
      bad++; $display("FAIL ovf_held: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, ed[0]);
    end
    m_axis_tready = 1; m_hold = 0; m_held = 0;
    @(negedge aclk);
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_tvalid_fall: got %b want 0", m_axis_tvalid); end
    model_word(c, 16'h0004, 1'b0, -1);
    send_word(c, 16'h0004, 1'b0, -1, 3*HB);
    drive(ID, 4*HB);
    total++;
    if (gd.size() != ed.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", gd.size(), ed.size()); end
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (i >= gd.size() || gd[i] !== ed[i] || gu[i] !== eu[i]) begin
        bad++; $display("FAIL ovf_beat%0d: got %h/%h want %h/%h", i, gd[i], gu[i], ed[i], eu[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [15:0] d;
    clear_q();
    d = 16'($urandom);
    // Parity flipped, Manchester violation in bit 5, then a clean word.
    model_word(1'b1, 16'h1234, 1'b1, -1);
    send_word(1'b1, 16'h1234, 1'b1, -1, 3*HB);
    drive(ID, 2*HB);
    model_word(1'b0, 16'h07FF, 1'b0, 5);
    send_word(1'b0, 16'h07FF, 1'b0, 5, 3*HB);
    drive(ID, 2*HB);
    model_word(1'b1, d, 1'b0, -1);
    send_word(1'b1, d, 1'b0, -1, 3*HB);
    drive(ID, 4*HB);
    total++;
    if (gd.size() != ed.size()) begin bad++; $display("FAIL err_count: got %0d want %0d", gd.size(), ed.size()); end
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (i >= gd.size() || gd[i] !== ed[i] || gu[i] !== eu[i]) begin
        bad++; $display("FAIL err_beat%0d: got %h/%h want %h/%h", i, gd[i], gu[i], ed[i], eu[i]);
      end
    end
  endtask

  task automatic test_bad_sync_and_reset();
    clear_q();
    send_word(1'b1, 16'($urandom), 1'b0, -1, 20);
    drive(ID, 4*HB);
    fork
      send_word(1'b0, 16'($urandom), 1'b0, -1, 3*HB);
      begin
        repeat (200) @(negedge aclk);
        arstn = 0;
        repeat (3) @(negedge aclk);
        arstn = 1;
        total++;
        if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL midreset_tvalid: got %b want 0", m_axis_tvalid); end
      end
    join
    drive(ID, 4*HB);
    total++;
    if (gd.size() != 0) begin bad++; $display("FAIL badsync_reset_count: got %0d beats want 0", gd.size()); end
  endtask

  task automatic test_random();
    bit c, pf, prevbad;
    int bb, kind;
    logic [15:0] d;
    clear_q();
    prevbad = 0;
    for (int w = 0; w < 10; w++) begin
      c = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      kind = $urandom_range(0, 4);
      pf = (kind == 0);
      bb = (kind == 1) ? $urandom_range(0, 16) : -1;
      if (prevbad) drive(ID, 2*HB);
      else if ($urandom_range(0, 1) == 1) drive(ID, HB);
      model_word(c, d, pf, bb);
      send_word(c, d, pf, bb, 3*HB);
      prevbad = (bb >= 0);
    end
    drive(ID, 4*HB);
    total++;
    if (gd.size() != ed.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", gd.size(), ed.size()); end
    for (int i = 0; i < ed.size(); i++) begin
      total++;
      if (i >= gd.size() || gd[i] !== ed[i] || gu[i] !== eu[i]) begin
        bad++; $display("FAIL rand_beat%0d: got %h/%h want %h/%h", i, gd[i], gu[i], ed[i], eu[i]);
      end
    end
  endtask

  initial begin
    aclk = 0; arstn = 0; diff = ID; m_axis_tready = 1;
    @(negedge aclk);
    test_reset();
    test_cmd_word();
    test_back_to_back();
    test_overflow();
    test_errors();
    test_bad_sync_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
